// File: rtl/maze_mesh_pkg.sv
// Shared mesh definitions: direction indices, direction vector types and
// the default flit payload width used by the input and output buffers.
package maze_mesh_pkg;

  localparam int DIR_N      = 0;
  localparam int DIR_W      = 1;
  localparam int DIR_S      = 2;
  localparam int DIR_E      = 3;
  localparam int DIR_B      = 4;
  localparam int NUM_DIR    = 5;
  localparam int DEF_PYLD_W = 23;

  typedef logic [NUM_DIR-1:0] dir_vec_t;
  typedef logic [2:0]         dir_idx_t;

  // Encode a one-hot direction vector to its index (0 when empty).
  function automatic dir_idx_t onehot_to_idx(input dir_vec_t v);
    dir_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      if (v[i]) idx = dir_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb5.sv
// Five-way round-robin arbiter. Searches upward from the source after
// 'last', wrapping 4->0, and grants the first requester. No grant when
// 'en' is low.
module rr_arb5
  import maze_mesh_pkg::*;
(
  input  dir_vec_t req,
  input  logic     en,
  input  dir_idx_t last,
  output dir_vec_t gnt
);

  logic     found;
  dir_idx_t idx;

  // Rotating priority search starting one past the last winner.
  always_comb begin
    // NOTE: every signal gets a default before any conditional write so no latch is inferred.
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_DIR; k++) begin
      idx = dir_idx_t'((int'(last) + k) % NUM_DIR);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/obuf_rr_out.sv
// Per-direction output buffer: round-robin grant over the five input
// buffers, a small FIFO, and a vld/rdy link interface.
// Optional macro OBUF_BYPASS_EN: an empty buffer forwards the granted
// payload to the link in the same cycle (zero-latency bypass).
module obuf_rr_out
  import maze_mesh_pkg::*;
#(
  parameter int PYLD_W = DEF_PYLD_W,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pg_en,
  input  logic [NUM_DIR-1:0]        in_req,
  input  logic [NUM_DIR*PYLD_W-1:0] in_payload,
  output logic [NUM_DIR-1:0]        arb_gnt,
  output logic                      obuf_rdy,
  output logic                      link_vld,
  input  logic                      link_rdy,
  output logic [PYLD_W-1:0]         link_payload,
  output logic [PTR_W:0]            occ
);

  logic [PTR_W:0]    count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  dir_idx_t          rr_last;
  // Sized to the full pointer range so pointer indexing is width-exact;
  // only the first DEPTH entries are ever addressed.
  logic [PYLD_W-1:0] mem [2**PTR_W];

  logic              accept;
  dir_idx_t          gnt_idx;
  logic [PYLD_W-1:0] gnt_payload;
  logic              mem_vld;
  logic              bypass;
  logic              bypass_take;
  logic              mem_wr;
  logic              mem_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Readiness comes only from registered count; rst forces it low.
  assign obuf_rdy = ~rst & ~pg_en & (count < (PTR_W+1)'(DEPTH));

  rr_arb5 u_arb (
    .req  (in_req),
    .en   (obuf_rdy),
    .last (rr_last),
    .gnt  (arb_gnt)
  );

  assign accept      = |arb_gnt;
  assign gnt_idx     = onehot_to_idx(arb_gnt);
  assign gnt_payload = in_payload[int'(gnt_idx)*PYLD_W +: PYLD_W];
  assign mem_vld     = (count != '0);

`ifdef OBUF_BYPASS_EN
  assign bypass = accept & ~mem_vld;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed flit taken by the link in the same cycle is never stored.
  assign bypass_take  = bypass & link_rdy;
  assign mem_wr       = accept & ~bypass_take;
  assign mem_pop      = mem_vld & link_rdy;

  assign link_vld     = mem_vld | bypass;
  assign link_payload = bypass ? gnt_payload : mem[rd_ptr];
  assign occ          = count;

  // Pointers, occupancy and round-robin state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rr_last <= dir_idx_t'(DIR_B);
    end else begin
      if (mem_wr)  wr_ptr  <= ptr_inc(wr_ptr);
      if (mem_pop) rd_ptr  <= ptr_inc(rd_ptr);
      if (accept)  rr_last <= gnt_idx;
      case ({mem_wr, mem_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count gates its use, so stale contents are never observed.
    if (mem_wr) mem[wr_ptr] <= gnt_payload;
  end

endmodule

// File: tb/tb_obuf_rr_out.sv
// Self-checking bench for obuf_rr_out: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model with
// a scoreboard monitor on the outgoing link.
module tb_obuf_rr_out;
  import maze_mesh_pkg::*;

  localparam int PYLD_W = 23;
  localparam int DEPTH  = 2;
  localparam int PTR_W  = 3;

  logic                      clk;
  logic                      rst;
  logic                      pg_en;
  logic [NUM_DIR-1:0]        in_req;
  logic [NUM_DIR*PYLD_W-1:0] in_payload;
  logic [NUM_DIR-1:0]        arb_gnt;
  logic                      obuf_rdy;
  logic                      link_vld;
  logic                      link_rdy;
  logic [PYLD_W-1:0]         link_payload;
  logic [PTR_W:0]            occ;

  obuf_rr_out #(.PYLD_W(PYLD_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .pg_en        (pg_en),
    .in_req       (in_req),
    .in_payload   (in_payload),
    .arb_gnt      (arb_gnt),
    .obuf_rdy     (obuf_rdy),
    .link_vld     (link_vld),
    .link_rdy     (link_rdy),
    .link_payload (link_payload),
    .occ          (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                n_checks = 0;
  int                n_fail   = 0;
  logic [PYLD_W-1:0] exp_q[$];   // scoreboard: flits expected on the link, in order
  logic [PYLD_W-1:0] fifo_m[$];  // model of buffered flits
  int                rr_last_m;
  logic [4:0]        src_req;
  logic [PYLD_W-1:0] src_pl [NUM_DIR];
  logic [4:0]        last_gnt_m;
  logic [4:0]        last_dut_gnt;

  always_comb begin
    in_req     = src_req;
    in_payload = '0;
    for (int i = 0; i < NUM_DIR; i++) in_payload[i*PYLD_W +: PYLD_W] = src_pl[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: check combinational outputs against the model at the
  // falling edge, then advance the model at the rising edge.
  task automatic step();
    int         g;
    logic       rdy;
    logic [4:0] gnt;
    logic       byp;
    logic       vld;
    @(negedge clk);
    rdy = !pg_en && (fifo_m.size() < DEPTH);
    gnt = '0;
    g   = -1;
    if (rdy) begin
      for (int k = 1; k <= NUM_DIR; k++) begin
        int i = (rr_last_m + k) % NUM_DIR;
        if (g < 0 && src_req[i]) begin
          g      = i;
          gnt[i] = 1'b1;
        end
      end
    end
    byp = 1'b0;
`ifdef OBUF_BYPASS_EN
    byp = (g >= 0) && (fifo_m.size() == 0);
`endif
    vld = (fifo_m.size() != 0) || byp;
    check("arb_gnt",  32'(arb_gnt),  32'(gnt));
    check("obuf_rdy", 32'(obuf_rdy), 32'(rdy));
    check("link_vld", 32'(link_vld), 32'(vld));
    check("occ",      32'(occ),      32'(fifo_m.size()));
    last_dut_gnt = arb_gnt;
    last_gnt_m   = gnt;
    if (g >= 0) exp_q.push_back(src_pl[g]);
    @(posedge clk);
    if (link_rdy && fifo_m.size() != 0) void'(fifo_m.pop_front());
    if (g >= 0) begin
      if (!(byp && link_rdy)) fifo_m.push_back(src_pl[g]);
      rr_last_m = g;
    end
    #1;
  endtask

  // Scoreboard monitor: every link handshake must carry the oldest expected flit.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && link_vld && link_rdy) begin
        if (exp_q.size() == 0) check("unexpected_flit", 32'(link_payload), 32'hDEAD_BEEF);
        else                   check("link_payload", 32'(link_payload), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    pg_en     = 1'b0;
    link_rdy  = 1'b0;
    src_req   = 5'b11111;
    rr_last_m = DIR_B;
    for (int i = 0; i < NUM_DIR; i++) src_pl[i] = PYLD_W'($urandom);

    // Reset state: grants suppressed even with requests present.
    #12;
    check("rst_gnt",  32'(arb_gnt),  32'd0);
    check("rst_rdy",  32'(obuf_rdy), 32'd0);
    check("rst_vld",  32'(link_vld), 32'd0);
    check("rst_occ",  32'(occ),      32'd0);
    src_req = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // N and S request: N first, then S; payloads leave in that order.
    src_pl[DIR_N] = PYLD_W'($urandom);
    src_pl[DIR_S] = PYLD_W'($urandom);
    src_req  = 5'b00101;
    link_rdy = 1'b1;
    step();
    check("t1_first_gnt", 32'(last_dut_gnt), 32'h01);
    src_req = src_req & ~last_gnt_m;
    step();
    check("t1_second_gnt", 32'(last_dut_gnt), 32'h04);
    src_req = '0;
    repeat (3) step();

    // Reset mid-operation with one flit stored.
    src_pl[DIR_N] = PYLD_W'($urandom);
    src_req  = 5'b00001;
    link_rdy = 1'b0;
    step();
    src_req = '0;
    step();
    check("t5_pre_vld", 32'(link_vld), 32'd1);
    check("t5_pre_occ", 32'(occ),      32'd1);
    rst = 1'b1;
    #2;
    check("t5_rst_vld", 32'(link_vld), 32'd0);
    check("t5_rst_occ", 32'(occ),      32'd0);
    exp_q.delete();
    fifo_m.delete();
    rr_last_m = DIR_B;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All five requesting continuously: N,W,S,E,B,N.
    link_rdy = 1'b1;
    src_req  = 5'b11111;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NUM_DIR; i++) src_pl[i] = PYLD_W'($urandom);
      step();
      check($sformatf("t2_seq%0d", n), 32'(last_dut_gnt), 32'(1 << (n % NUM_DIR)));
    end
    src_req = '0;
    repeat (3) step();

    // Backpressure fills the FIFO; space returns the cycle after a pop.
    link_rdy = 1'b0;
    src_req  = 5'b10000;
    repeat (4) begin
      src_pl[DIR_B] = PYLD_W'($urandom);
      step();
    end
    check("t3_full_occ", 32'(occ),          32'd2);
    check("t3_full_rdy", 32'(obuf_rdy),     32'd0);
    check("t3_full_gnt", 32'(last_dut_gnt), 32'd0);
    link_rdy = 1'b1;
    step();
    check("t3_rdy_after_pop", 32'(obuf_rdy), 32'd1);
    step();

    // Power gate with a full FIFO: drains, no new grants.
    link_rdy = 1'b0;
    repeat (3) begin
      src_pl[DIR_B] = PYLD_W'($urandom);
      step();
    end
    src_req = '0;
    check("t4_pre_occ", 32'(occ), 32'd2);
    pg_en    = 1'b1;
    link_rdy = 1'b1;
    src_req  = 5'b11111;
    for (int i = 0; i < NUM_DIR; i++) src_pl[i] = PYLD_W'($urandom);
    repeat (4) step();
    check("t4_occ_drained", 32'(occ),      32'd0);
    check("t4_rdy_gated",   32'(obuf_rdy), 32'd0);
    pg_en = 1'b0;
    #1;
    check("t4_rdy_ungated", 32'(obuf_rdy), 32'd1);
    step();
    src_req = src_req & ~last_gnt_m;

    // Randomized traffic; sources drop a request once granted.
    for (int c = 0; c < 3000; c++) begin
      link_rdy = ($urandom_range(0, 3) != 0);
      pg_en    = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NUM_DIR; i++) begin
        if (!src_req[i] && $urandom_range(0, 2) == 0) begin
          src_req[i] = 1'b1;
          src_pl[i]  = PYLD_W'($urandom);
        end
      end
      step();
      src_req = src_req & ~last_gnt_m;
    end

    // Drain whatever remains.
    pg_en    = 1'b0;
    src_req  = '0;
    link_rdy = 1'b1;
    for (int i = 0; i < 20 && fifo_m.size() != 0; i++) step();
    step();
    check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("drain_occ",              32'(occ),          32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
